// File: rtl/ps_link_ctrl_if.sv
// rtl/ps_link_ctrl_if.sv - byte-source handshake and serial-lane signal bundle for ps_link_ctrl
interface ps_link_ctrl_if;
    logic [7:0] data_in0;
    logic       valid_in0;
    logic       ready0;
    logic [7:0] data_in1;
    logic       valid_in1;
    logic       ready1;
    logic       data_out;
    logic [2:0] phase;
    logic       byte_start;
    logic       lane_sel;
    logic       data_active;

    // Byte producers and lane observers
    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  ready0, ready1, data_out, phase, byte_start, lane_sel, data_active
    );

    // Link controller
    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output ready0, ready1, data_out, phase, byte_start, lane_sel, data_active
    );
endinterface

// File: rtl/ps_link_ctrl.sv
// rtl/ps_link_ctrl.sv - two-lane round-robin byte scheduler feeding an MSB-first serial shift register
module ps_link_ctrl #(
    parameter logic [7:0] IDLE_BYTE  = 8'hBC,
    parameter int         SYNC_BYTES = 4
) (
    input  logic          clk_8f,
    input  logic          reset,
    ps_link_ctrl_if.slave link
);

    localparam int CW = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;
    localparam logic [CW-1:0] SYNC_INIT = CW'(SYNC_BYTES - 1);
    localparam logic [CW-1:0] SYNC_ONE  = CW'(1);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t        state_q;
    logic [2:0]    phase_q;
    logic [7:0]    shreg_q;
    logic [CW-1:0] sync_cnt_q;
    logic          last_q;
    logic          lane_sel_q;
    logic          data_active_q;

    logic load_slot;
    logic eligible;
    logic grant0;
    logic grant1;

    // Slot arbitration; reset suppresses any grant so no handshake completes under reset
    always_comb begin
        load_slot = (phase_q == 3'd7);
        eligible  = (state_q == ST_ACTIVE) || (sync_cnt_q == '0);
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!reset && load_slot && eligible) begin
            if (link.valid_in0 && link.valid_in1) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = link.valid_in0;
                grant1 = link.valid_in1;
            end
        end
    end

    assign link.ready0      = grant0;
    assign link.ready1      = grant1;
    assign link.data_out    = shreg_q[7];
    assign link.phase       = phase_q;
    assign link.byte_start  = (phase_q == 3'd0);
    assign link.lane_sel    = lane_sel_q;
    assign link.data_active = data_active_q;

    // Bit timing, sync countdown and byte loading; all tags update only at the load slot
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            phase_q       <= 3'd0;
            shreg_q       <= IDLE_BYTE;
            state_q       <= ST_SYNC;
            sync_cnt_q    <= SYNC_INIT;
            last_q        <= 1'b1;
            lane_sel_q    <= 1'b0;
            data_active_q <= 1'b0;
        end else begin
            phase_q <= phase_q + 3'd1;
            if (!load_slot) begin
                shreg_q <= {shreg_q[6:0], 1'b0};
            end else begin
                if (state_q == ST_SYNC) begin
                    if (sync_cnt_q != '0) begin
                        sync_cnt_q <= sync_cnt_q - SYNC_ONE;
                    end else begin
                        state_q <= ST_ACTIVE;
                    end
                end
                if (grant0) begin
                    shreg_q       <= link.data_in0;
                    lane_sel_q    <= 1'b0;
                    data_active_q <= 1'b1;
                    last_q        <= 1'b0;
                end else if (grant1) begin
                    shreg_q       <= link.data_in1;
                    lane_sel_q    <= 1'b1;
                    data_active_q <= 1'b1;
                    last_q        <= 1'b1;
                end else begin
                    shreg_q       <= IDLE_BYTE;
                    data_active_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps_link_ctrl.sv
// tb/tb_ps_link_ctrl.sv - table vectors, corner sequences and randomized model check for ps_link_ctrl
module tb_ps_link_ctrl;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         SYNC = 4;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       chk;
        logic       r0;
        logic       r1;
        logic       dout;
        logic       act;
        logic       lane;
        logic [2:0] ph;
    } vec_t;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;

    ps_link_ctrl_if link ();

    ps_link_ctrl #(.IDLE_BYTE(IDLE), .SYNC_BYTES(SYNC)) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .link   (link)
    );

    always #5 clk_8f = ~clk_8f;

    int total = 0;
    int bad   = 0;
    int cnt_r0 = 0;
    int cnt_r1 = 0;
    int cyc   = 0;

    // Reference: cycles since reset release, the byte currently on the wire, and its tags
    int         m_n = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_act = 1'b0;
    logic       m_lane = 1'b0;
    logic       m_last = 1'b1;
    logic       m_known = 1'b0;
    logic       m_acc0 = 1'b0;
    logic       m_acc1 = 1'b0;

    vec_t tbl[$];

    function automatic logic bit_at(input logic [7:0] b, input int i);
        return b[7 - i];
    endfunction

    task automatic add(input logic rst, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic chk,
                       input logic r0, input logic r1, input logic dout,
                       input logic act, input logic lane, input int ph);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.chk = chk;
        v.r0 = r0; v.r1 = r1; v.dout = dout; v.act = act; v.lane = lane; v.ph = 3'(ph);
        tbl.push_back(v);
    endtask

    task automatic step(input vec_t v);
        int         ph;
        int         sel;
        logic       el;
        logic       g0;
        logic       g1;
        logic [8:0] ex;
        logic [8:0] ob;
        logic [5:0] tex;
        logic [5:0] tob;
        reset          = v.rst;
        link.valid_in0 = v.v0;
        link.data_in0  = v.d0;
        link.valid_in1 = v.v1;
        link.data_in1  = v.d1;
        @(negedge clk_8f);
        cnt_r0 += int'(link.ready0);
        cnt_r1 += int'(link.ready1);
        ph  = m_n % 8;
        el  = !v.rst && (ph == 7) && ((m_n / 8) >= SYNC - 1);
        sel = -1;
        if (v.v0 && v.v1) sel = m_last ? 0 : 1;
        else if (v.v0)    sel = 0;
        else if (v.v1)    sel = 1;
        g0 = el && (sel == 0);
        g1 = el && (sel == 1);
        ob = {link.ready0, link.ready1, link.data_out, link.phase, link.byte_start,
              link.lane_sel, link.data_active};
        if (m_known) begin
            ex = {g0, g1, m_byte[7 - ph], 3'(ph), (ph == 0), m_lane, m_act};
            total++;
            if (ob !== ex) begin
                bad++;
                $display("FAIL model cyc=%0d got r0r1_do_ph_bs_lane_act=%b want %b", cyc, ob, ex);
            end
        end
        if (v.chk) begin
            tob = {link.ready0, link.ready1, link.data_out, link.data_active, link.lane_sel, 1'b0};
            tex = {v.r0, v.r1, v.dout, v.act, v.lane, 1'b0};
            total++;
            if (tob !== tex || link.phase !== v.ph) begin
                bad++;
                $display("FAIL table cyc=%0d got r0r1_do_act_lane=%b ph=%0d want %b ph=%0d",
                         cyc, tob[5:1], link.phase, tex[5:1], v.ph);
            end
        end
        @(posedge clk_8f);
        if (v.rst) begin
            m_known = 1'b1; m_n = 0; m_byte = IDLE; m_act = 1'b0;
            m_lane = 1'b0; m_last = 1'b1; m_acc0 = 1'b0; m_acc1 = 1'b0;
        end else if (m_known) begin
            m_acc0 = g0;
            m_acc1 = g1;
            if (ph == 7) begin
                if (g0) begin
                    m_byte = v.d0; m_act = 1'b1; m_lane = 1'b0; m_last = 1'b0;
                end else if (g1) begin
                    m_byte = v.d1; m_act = 1'b1; m_lane = 1'b1; m_last = 1'b1;
                end else begin
                    m_byte = IDLE; m_act = 1'b0;
                end
            end
            m_n++;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic rst, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.chk = 1'b0;
        v.r0 = 1'b0; v.r1 = 1'b0; v.dout = 1'b0; v.act = 1'b0; v.lane = 1'b0; v.ph = 3'd0;
        step(v);
    endtask

    task automatic expect_count(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    initial begin
        logic       rv0;
        logic       rv1;
        logic       rst;
        logic       pv0;
        logic       pv1;
        logic [7:0] rd0;
        logic [7:0] rd1;

        link.valid_in0 = 1'b0;
        link.valid_in1 = 1'b0;
        link.data_in0  = 8'h00;
        link.data_in1  = 8'h00;

        // Idle after reset: comma pattern repeats, nothing granted
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 64; c++)
            add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, bit_at(IDLE, c % 8), 0, 0, c % 8);

        // Lane 0 byte A5 waiting from cycle 0: accepted at 31, on the wire 32..39
        add(1, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 48; c++)
            add(0, c <= 31, 8'hA5, 0, 8'h00, 1, c == 31, 0,
                (c >= 32 && c < 40) ? bit_at(8'hA5, c - 32) : bit_at(IDLE, c % 8),
                (c >= 32 && c < 40), 0, c % 8);

        // Reset at phase 4 of a data byte: abort, realign, full sync before next ready
        add(1, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 36; c++)
            add(0, c <= 31, 8'hA5, 0, 8'h00, 1, c == 31, 0,
                (c >= 32) ? bit_at(8'hA5, c - 32) : bit_at(IDLE, c % 8), c >= 32, 0, c % 8);
        add(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, bit_at(8'hA5, 4), 1, 0, 4);
        for (int c = 0; c < 40; c++)
            add(0, c <= 31, 8'h3C, 0, 8'h00, 1, c == 31, 0,
                (c >= 32) ? bit_at(8'h3C, c - 32) : bit_at(IDLE, c % 8), c >= 32, 0, c % 8);

        // Reset asserted exactly at the first eligible slot with valid high: no ready
        add(1, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 31; c++)
            add(0, 1, 8'h5A, 0, 8'h00, 1, 0, 0, bit_at(IDLE, c % 8), 0, 0, c % 8);
        add(1, 1, 8'h5A, 0, 8'h00, 1, 0, 0, bit_at(IDLE, 7), 0, 0, 7);
        for (int c = 0; c < 8; c++)
            add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, bit_at(IDLE, c), 0, 0, c);

        foreach (tbl[i]) step(tbl[i]);

        // Both lanes always valid: 0,1,0,1,... one per slot from cycle 31
        drive(1, 0, 8'h00, 0, 8'h00);
        cnt_r0 = 0; cnt_r1 = 0;
        for (int c = 0; c < 80; c++) drive(0, 1, 8'h11, 1, 8'h22);
        expect_count("alt_ready0", cnt_r0, 4);
        expect_count("alt_ready1", cnt_r1, 3);

        // Lane 1 valid only outside the load slot: never accepted
        drive(1, 0, 8'h00, 0, 8'h00);
        cnt_r0 = 0; cnt_r1 = 0;
        for (int c = 0; c < 64; c++) drive(0, 0, 8'h00, (c % 8) != 7, 8'h77);
        expect_count("pulse_ready1", cnt_r1, 0);

        // Lane 0 alone, lane 1 joins at cycle 40: lane 1 wins slot 47, then alternation
        drive(1, 0, 8'h00, 0, 8'h00);
        cnt_r0 = 0; cnt_r1 = 0;
        for (int c = 0; c < 72; c++) drive(0, 1, 8'h0F, c >= 40, 8'hF0);
        expect_count("join_ready0", cnt_r0, 4);
        expect_count("join_ready1", cnt_r1, 2);

        // Randomized traffic; sources hold a byte until the reference sees it accepted
        pv0 = 1'b0; pv1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0; rd0 = 8'h00; rd1 = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 399) == 0);
            if (!pv0) begin rv0 = ($urandom_range(0, 2) != 0); rd0 = 8'($urandom); end
            if (!pv1) begin rv1 = ($urandom_range(0, 2) != 0); rd1 = 8'($urandom); end
            drive(rst, rv0, rd0, rv1, rd1);
            pv0 = rv0 && !m_acc0 && !rst;
            pv1 = rv1 && !m_acc1 && !rst;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps_link_ctrl.md
# ps_link_ctrl

Transmit-side controller for the parallel-to-serial link. It arbitrates round-robin between two 8-bit byte sources and schedules one byte every 8 `clk_8f` cycles into an internal MSB-first shift register. When no source is granted it inserts an idle/comma byte, and after reset it forces a fixed number of idle bytes for receiver alignment. It sits between the byte producers (clocked at the `clk_f` rate) and the serial lane driven at `clk_8f`.

## Interface
Parameters:
- `IDLE_BYTE`, 8'hBC: byte transmitted when no data is granted, and during sync.
- `SYNC_BYTES`, 4: idle bytes forced after reset before any grant (≥1).

Ports:
- `clk_8f`  in  1  bit clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `data_in0`  in  8  lane 0 byte
- `valid_in0`  in  1  lane 0 byte available
- `ready0`  out  1  lane 0 byte accepted this cycle (combinational)
- `data_in1`  in  8  lane 1 byte
- `valid_in1`  in  1  lane 1 byte available
- `ready1`  out  1  lane 1 byte accepted this cycle (combinational)
- `data_out`  out  1  serial bit, equals `shreg[7]`
- `phase`  out  3  bit index within the current byte (0 = MSB)
- `byte_start`  out  1  high when `phase == 0`
- `lane_sel`  out  1  source lane of the byte on the wire
- `data_active`  out  1  1 = byte on the wire is data; 0 = idle

## Operation
- Registers: `phase[2:0]`, `shreg[7:0]`, `state` {SYNC, ACTIVE}, `sync_cnt`, `last` (last granted lane), `lane_sel`, `data_active`.
- Reset values: `phase`=0, `shreg`=`IDLE_BYTE`, `state`=SYNC, `sync_cnt`=`SYNC_BYTES`-1, `last`=1, `lane_sel`=0, `data_active`=0. This gives `data_out`=`IDLE_BYTE[7]`, `byte_start`=1, `ready0`=`ready1`=0.
- `phase` increments every cycle and wraps 7→0.
- Phase 0–6: `shreg` shifts left by one, LSB filled with 0.
- Load slot is phase 7. `eligible` = (state==ACTIVE) or (sync_cnt==0).
- SYNC behaviour at phase 7:
  - `sync_cnt` != 0: decrement `sync_cnt` and load `IDLE_BYTE`.
  - `sync_cnt` == 0: go to ACTIVE and arbitrate in the same cycle.
- Arbitration, only at phase 7 with `eligible`:
  - Only one lane valid: grant that lane.
  - Both lanes valid: grant the lane != `last`.
  - Neither valid: no grant.
- Grant on lane k:
  - `readyk`=1 for that cycle only.
  - Load `data_ink` into `shreg`.
  - Set `lane_sel`=k, `data_active`=1, `last`=k.
- No grant: load `IDLE_BYTE`, set `data_active`=0, leave `lane_sel` and `last` unchanged.
- Handshake: a transfer occurs only when `validk && readyk`. Valid outside phase 7 is ignored. Sources hold valid and data until accepted.
- `ready0` and `ready1` are never both 1. Neither is ever 1 outside phase 7.

## Timing
- Byte accepted at the phase-7 edge. Its MSB is on `data_out` the next cycle (phase 0) and its LSB at phase 7. Latency from the accepting edge to MSB is 1 cycle.
- Throughput: 1 byte per 8 `clk_8f` cycles, with no gaps between bytes.
- After reset release:
  - Exactly `SYNC_BYTES` idle bytes are sent (cycles 0 .. 8·`SYNC_BYTES`-1).
  - The first possible `ready` is at cycle 8·`SYNC_BYTES`-1.
  - The first data MSB is at cycle 8·`SYNC_BYTES`.
- `lane_sel` and `data_active` change only at the phase-7 edge and stay aligned with the byte on the wire.
- Reset mid-byte: the partial byte is aborted next edge and all registers take their reset values. The next byte boundary is phase 0 in the following cycle. Sync is repeated in full.
- Reset asserted at phase 7 with valid high: reset wins, and no ready/transfer occurs.

## Test plan
- Reset, both valids low for 64 cycles → `data_out` repeats 1,0,1,1,1,1,0,0 every 8 cycles; `data_active`=0; `ready0`/`ready1` never 1.
- Reset, `data_in0`=8'hA5 with `valid_in0` high from cycle 0 → `ready0` pulses only at cycle 31; bits 1,0,1,0,0,1,0,1 on cycles 32–39; `lane_sel`=0; `data_active`=1 over cycles 32–39.
- Both lanes continuously valid (lane0 8'h11, lane1 8'h22) after sync → grants alternate 0,1,0,1… starting with lane 0; one byte per 8 cycles; no idle bytes between them.
- Lane1 `valid_in1` pulsed high only at phases 0–6 → no `ready1`, no transfer; idle bytes continue.
- Reset asserted at phase 4 of a data byte, released after 1 cycle → `data_out`=1 (IDLE MSB) and `phase`=0 the cycle after the reset edge; 4 idle bytes follow before any ready.
- Lane0 valid only, then lane1 valid joins → lane1 is granted at the next slot (`last`=0); afterwards grants alternate.
